uart_tx_drain: RTL and testbench
================================

// Module: uart_tx_drain
// PURPOSE
//  UART transmitter that drains the 8-bit byte FIFO (push/pop, full/empty) one byte per frame.
//  Pops a byte when the FIFO is non-empty, serialises it as 8N1/8N2 (optional parity), LSB first.
//  Sits directly downstream of the FIFO: empty -> this block, this block's pop -> FIFO,
//  FIFO dout -> din. The FIFO updates dout on the edge that samples pop=1.
// PARAMETERS
//  CLKS_PER_BIT  868  clock cycles per bit period (100 MHz / 115200); legal range >= 2
//  STOP_BITS     1    number of stop bits; legal values 1 or 2
// PORTS
//  clk    in   1  single system clock; all logic on the rising edge
//  rst    in   1  synchronous, active-high reset
//  empty  in   1  FIFO empty flag
//  din    in   8  FIFO dout, valid in the cycle after pop
//  pop    out  1  one-cycle FIFO read strobe
//  tx     out  1  serial line; idles high; registered
//  busy   out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset: at the first edge with rst=1 -> state=IDLE, tx=1, pop=0, busy=0; counters and shift reg = 0.
//  Reset mid-frame aborts the frame at that edge. The popped byte is lost, and tx returns high immediately.
//  FSM (registered state; pop and busy decode from state):
//   IDLE   tx=1. If empty=0 is sampled -> POP; otherwise stay.
//   POP    pop=1 for exactly this cycle -> LOAD
//   LOAD   shreg <= din -> START; tx <= 0 on this edge
//   START  tx=0 for CLKS_PER_BIT cycles -> DATA
//   DATA   tx=shreg[bit_idx], bit_idx 0..7, each bit held CLKS_PER_BIT cycles -> PARITY (if enabled), else STOP
//   PARITY tx=^shreg for CLKS_PER_BIT cycles -> STOP
//   STOP   tx=1 for STOP_BITS*CLKS_PER_BIT cycles -> IDLE
//  Counters:
//   baud_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary;
//     width = $clog2(CLKS_PER_BIT).
//   bit_idx is 3 bits and wraps 7 -> 0 only on the DATA exit.
//   stop_cnt counts stop bits.
//  Latency: with IDLE sampling empty=0 at edge E0, pop is high during E0..E1 and tx falls at E2.
//  Frame length, including START, is (1+8+P+STOP_BITS)*CLKS_PER_BIT cycles.
//   P = 1 when parity is enabled, 0 otherwise.
//  Back-to-back frames: tx stays high for exactly 3 extra cycles (IDLE, POP, LOAD) between the end of STOP and the next START.
//  Pop is never asserted while empty=1 is sampled in IDLE.
//  Empty is ignored outside IDLE. Changes on din outside LOAD have no effect.
//  Pop occurs only on the IDLE->POP path. Exactly one pop is issued per transmitted frame.
//  Parameter checks: an illegal CLKS_PER_BIT or STOP_BITS triggers $error at elaboration.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: the PARITY state is compiled in.
//   It inserts one even-parity bit (XOR of the 8 data bits) after bit 7, giving an 8E1/8E2 frame.
//  UART_TX_PARITY_EN undefined: no PARITY state and no parity logic.
//   DATA goes directly to STOP, giving an 8N1/8N2 frame.
// TESTING  (CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
//  1 Reset: rst=1 for 4 cycles, empty=1
//    -> tx=1, pop=0, busy=0 after the first reset edge; remains so after rst drops.
//  2 Single byte: din=0x55, empty falls for 1 byte
//    -> one pop pulse; tx=0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4; frame length 40 cycles.
//    -> busy falls after STOP.
//  3 Back-to-back: FIFO holds 0x00, 0xFF, 0xA5
//    -> exactly 3 pops; decoded bytes are 0x00, 0xFF, 0xA5; a 3-cycle idle-high gap between frames.
//  4 Starvation: empty=1 for 1000 cycles after reset -> pop never asserts, tx=1, busy=0.
//  5 Reset mid-frame: rst=1 for one cycle during data bit 3 of 0xC3
//    -> tx=1, busy=0 at the next edge; the next queued byte transmits cleanly from a fresh START.
//  6 Parity (UART_TX_PARITY_EN, STOP_BITS=2): byte 0x07
//    -> parity bit =1, two stop bits, frame length 48 cycles. The same bench without the macro gives a 44-cycle frame with no parity bit.

Source files
------------

// File: rtl/uart_tx_drain_if.sv
// uart_tx_drain_if: FIFO read port (empty/din/pop) between a byte FIFO and the UART transmitter
interface uart_tx_drain_if;
    logic       empty;
    logic [7:0] din;
    logic       pop;
    modport master (output empty, output din, input  pop);
    modport slave  (input  empty, input  din, output pop);
endinterface

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: UART transmitter draining a byte FIFO, 8N1/8N2 LSB first; define UART_TX_PARITY_EN for 8E1/8E2
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_drain_if.slave fifo,
    output logic           o_tx,
    output logic           o_busy
);
    localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_drain: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_drain: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [BW-1:0] r_baud, w_baud_nxt, w_baud_inc;
    logic [2:0]    r_bit, w_bit_nxt;
    logic          r_stop, w_stop_nxt;
    logic [7:0]    r_shreg, w_shreg_nxt;
    logic          r_tx, w_tx_nxt;
    logic          w_baud_last;

    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_baud_inc  = w_baud_last ? '0 : r_baud + 1'b1;
    assign fifo.pop    = (r_state == POP);
    assign o_busy      = (r_state != IDLE);
    assign o_tx        = r_tx;

    // next state, counters and the registered line level for the coming cycle
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = '0;
        w_bit_nxt   = r_bit;
        w_stop_nxt  = r_stop;
        w_shreg_nxt = r_shreg;
        w_tx_nxt    = r_tx;
        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (!fifo.empty) w_state_nxt = POP;
            end
            POP: w_state_nxt = LOAD;
            LOAD: begin
                w_shreg_nxt = fifo.din;
                w_tx_nxt    = 1'b0;
                w_state_nxt = START;
            end
            START: begin
                w_baud_nxt = w_baud_inc;
                if (w_baud_last) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_shreg[0];
                end
            end
            DATA: begin
                w_baud_nxt = w_baud_inc;
                if (w_baud_last) begin
                    if (r_bit == 3'd7) begin
                        w_bit_nxt = 3'd0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = PARITY;
                        w_tx_nxt    = ^r_shreg;
`else
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                        w_stop_nxt  = 1'b0;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                        w_tx_nxt  = r_shreg[w_bit_nxt];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_baud_nxt = w_baud_inc;
                if (w_baud_last) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
                    w_stop_nxt  = 1'b0;
                end
            end
`endif
            STOP: begin
                w_baud_nxt = w_baud_inc;
                if (w_baud_last) begin
                    if (r_stop == STOP_LAST) begin
                        w_state_nxt = IDLE;
                        w_stop_nxt  = 1'b0;
                    end else begin
                        w_stop_nxt = r_stop + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // state and datapath registers; reset aborts any frame and drives the line high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_shreg <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_stop  <= w_stop_nxt;
            r_shreg <= w_shreg_nxt;
            r_tx    <= w_tx_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: randomized self-checking bench with a FIFO model and a bit-level frame reference
module tb_uart_tx_drain;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P  = 1;
    localparam int SB = 2;
`else
    localparam int P  = 0;
    localparam int SB = 1;
`endif
    localparam int NB = 9 + P + SB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, busy;
    logic [7:0] fq[$];
    logic [7:0] nb;
    int n_chk = 0, n_err = 0, cyc = 0, pops = 0, pop_cyc = 0;

    always #5 clk = ~clk;

    uart_tx_drain_if bus();

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk   (clk),
        .rst   (rst),
        .fifo  (bus),
        .o_tx  (tx),
        .o_busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: dout updates on the edge that samples pop=1
    always @(posedge clk) begin
        if (bus.pop === 1'b1) begin
            check("pop_nonempty", fq.size() != 0, 1);
            if (fq.size() != 0) begin
                nb = fq.pop_front();
                bus.din <= nb;
            end
        end
        bus.empty <= (fq.size() == 0);
    end

    always @(negedge clk) begin
        if (!rst && bus.pop === 1'b1) begin
            pops++;
            pop_cyc = cyc;
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic wait_fall(output int gap);
        gap = 0;
        tick();
        while (tx !== 1'b0 && gap < 400) begin
            gap++;
            tick();
        end
        check("fall_seen", tx, 0);
    endtask

    task automatic frame(input logic [7:0] b, input bit iso, output int gap);
        logic [CPB-1:0] sv;
        logic [7:0] got;
        logic e;
        got = '0;
        wait_fall(gap);
        if (tx !== 1'b0) return;
        check("latency", cyc - pop_cyc, 2);
        for (int k = 0; k < NB; k++) begin
            for (int c = 0; c < CPB; c++) begin
                if (k != 0 || c != 0) tick();
                sv[c] = tx;
            end
            e = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : (P == 1 && k == 9) ? ^b : 1'b1;
            check($sformatf("bit%0d_of_%02h", k, b), sv, {CPB{e}});
            if (k >= 1 && k <= 8) got[k-1] = sv[CPB/2];
        end
        check("byte", got, b);
        if (iso) begin
            check("busy_last_stop", busy, 1);
            tick();
            check("busy_after", busy, 0);
            check("tx_idle", tx, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, p0, viol, n;
        logic [7:0] r;
        logic [7:0] ex[$];
        tick();
        check("rst_tx", tx, 1);
        check("rst_pop", bus.pop, 0);
        check("rst_busy", busy, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("post_rst_tx", tx, 1);
        check("post_rst_busy", busy, 0);

        p0 = pops;
        viol = 0;
        repeat (1000) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || bus.pop !== 1'b0) viol++;
        end
        check("starve_viol", viol, 0);
        check("starve_pops", pops - p0, 0);

        p0 = pops;
        fq.push_back(8'h55);
        frame(8'h55, 1, g);
        check("single_pops", pops - p0, 1);

        p0 = pops;
        fq.push_back(8'h00);
        fq.push_back(8'hFF);
        fq.push_back(8'hA5);
        frame(8'h00, 0, g);
        frame(8'hFF, 0, g);
        check("gap1", g, 3);
        frame(8'hA5, 1, g);
        check("gap2", g, 3);
        check("b2b_pops", pops - p0, 3);

        p0 = pops;
        fq.push_back(8'h07);
        frame(8'h07, 1, g);
        check("par_pops", pops - p0, 1);

        p0 = pops;
        r = 8'($urandom);
        fq.push_back(8'hC3);
        fq.push_back(r);
        wait_fall(g);
        repeat (CPB * 4 + 1) tick();
        check("c3_bit3", tx, 0);
        rst = 1'b1;
        tick();
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        rst = 1'b0;
        frame(r, 1, g);
        check("abort_pops", pops - p0, 2);

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 3);
            ex.delete();
            for (int i = 0; i < n; i++) begin
                ex.push_back(8'($urandom));
                fq.push_back(ex[i]);
            end
            for (int i = 0; i < n; i++) begin
                frame(ex[i], i == n - 1, g);
                if (i > 0) check("rnd_gap", g, 3);
            end
            repeat ($urandom_range(0, 15)) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
